// File: rtl/riscv_dcache_ctrl.sv
// Data-cache miss controller: write-back / write-allocate, BEATS-word bursts on the memory bus.
// Latency: hits are combinational (0 cycles); clean miss BEATS+2 stall cycles, dirty miss 2*BEATS+2 with mem_ready high.
// Backpressure: stall holds the core while a miss is in flight; beat_cnt advances only on mem_ready.
// Optional: define DCACHE_MISALIGN_EN to honour cpu_misaligned / hit_misaligned / dirty_misaligned.
module riscv_dcache_ctrl #(
  parameter int BEATS = 4,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req_valid,
  input  logic          cpu_req_we,
  input  logic          cpu_misaligned,
  input  logic          hit,
  input  logic          dirty,
  input  logic          hit_misaligned,
  input  logic          dirty_misaligned,
  input  logic          mem_ready,
  output logic          stall,
  output logic          replace_tag,
  output logic          valid_in,
  output logic          dirty_in,
  output logic          idx_sel,
  output logic          tag_sel,
  output logic          mem_wr_req,
  output logic          mem_rd_req,
  output logic [CW-1:0] beat_cnt,
  output logic          data_we,
  output logic          data_src
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2,
    S_UPDATE    = 2'd3
  } state_t;

  localparam logic [CW-1:0] BEAT_LAST = CW'(BEATS - 1);
  localparam logic [CW-1:0] BEAT_ONE  = CW'(1);

  state_t        state_q;
  logic [CW-1:0] beat_q;
  logic          idx_q;

  logic req_hit;
  logic req_miss;
  logic pick;        // line chosen for the miss: 0 = index, 1 = index+1
  logic pick_dirty;  // dirty bit of the chosen line
  logic beat_last;

`ifdef DCACHE_MISALIGN_EN
  // A misaligned access only hits when both lines hit; if the first line
  // hits, the miss must be on index+1.
  assign req_hit    = cpu_req_valid && hit && (!cpu_misaligned || hit_misaligned);
  assign pick       = hit;
  assign pick_dirty = pick ? dirty_misaligned : dirty;
`else
  // Single-line accesses only; the second-line tag inputs are don't-care.
  logic unused_misalign;
  assign unused_misalign = ^{cpu_misaligned, hit_misaligned, dirty_misaligned};
  assign req_hit    = cpu_req_valid && hit;
  assign pick       = 1'b0;
  assign pick_dirty = dirty;
`endif

  assign req_miss  = cpu_req_valid && !req_hit;
  assign beat_last = (beat_q == BEAT_LAST);

  // Output decode from state and live inputs; reset forces everything low.
  always_comb begin
    stall       = 1'b0;
    replace_tag = 1'b0;
    valid_in    = 1'b0;
    dirty_in    = 1'b0;
    idx_sel     = 1'b0;
    tag_sel     = 1'b0;
    mem_wr_req  = 1'b0;
    mem_rd_req  = 1'b0;
    beat_cnt    = '0;
    data_we     = 1'b0;
    data_src    = 1'b0;
    if (!rst) begin
      idx_sel  = idx_q;
      beat_cnt = beat_q;
      case (state_q)
        S_IDLE: begin
          if (req_hit && cpu_req_we) begin
            // Store hit: write core data and mark the line dirty in one cycle.
            data_we     = 1'b1;
            replace_tag = 1'b1;
            valid_in    = 1'b1;
            dirty_in    = 1'b1;
          end
          if (req_miss) begin
            stall = 1'b1;
          end
        end
        S_WRITEBACK: begin
          stall      = 1'b1;
          mem_wr_req = 1'b1;
          tag_sel    = 1'b1;
        end
        S_ALLOCATE: begin
          stall      = 1'b1;
          mem_rd_req = 1'b1;
          data_src   = 1'b1;
          data_we    = mem_ready;
          if (mem_ready && beat_last) begin
            // Refill complete: install a clean, valid tag.
            replace_tag = 1'b1;
            valid_in    = 1'b1;
          end
        end
        S_UPDATE: begin
          stall = 1'b1;
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

  // State, beat counter and selected-line register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      idx_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          beat_q <= '0;
          if (req_miss) begin
            idx_q   <= pick;
            state_q <= pick_dirty ? S_WRITEBACK : S_ALLOCATE;
          end
        end
        S_WRITEBACK: begin
          if (mem_ready) begin
            beat_q <= beat_q + BEAT_ONE;
            if (beat_last) begin
              state_q <= S_ALLOCATE;
            end
          end
        end
        S_ALLOCATE: begin
          if (mem_ready) begin
            if (beat_last) begin
              beat_q  <= '0;
              state_q <= S_UPDATE;
            end else begin
              beat_q <= beat_q + BEAT_ONE;
            end
          end
        end
        S_UPDATE: begin
          idx_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_dcache_ctrl.sv
// Directed bench for riscv_dcache_ctrl: hits, clean/dirty misses, stalling memory, reset mid-burst.
// Inputs change 1 ns after posedge; outputs are sampled on negedge.
// Expected output vectors are hand-built per cycle from the controller's documented behaviour.
module tb_riscv_dcache_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req_valid;
  logic       cpu_req_we;
  logic       cpu_misaligned;
  logic       hit;
  logic       dirty;
  logic       hit_misaligned;
  logic       dirty_misaligned;
  logic       mem_ready;
  logic       stall;
  logic       replace_tag;
  logic       valid_in;
  logic       dirty_in;
  logic       idx_sel;
  logic       tag_sel;
  logic       mem_wr_req;
  logic       mem_rd_req;
  logic [1:0] beat_cnt;
  logic       data_we;
  logic       data_src;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  riscv_dcache_ctrl #(.BEATS(4), .CW(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .cpu_req_valid    (cpu_req_valid),
    .cpu_req_we       (cpu_req_we),
    .cpu_misaligned   (cpu_misaligned),
    .hit              (hit),
    .dirty            (dirty),
    .hit_misaligned   (hit_misaligned),
    .dirty_misaligned (dirty_misaligned),
    .mem_ready        (mem_ready),
    .stall            (stall),
    .replace_tag      (replace_tag),
    .valid_in         (valid_in),
    .dirty_in         (dirty_in),
    .idx_sel          (idx_sel),
    .tag_sel          (tag_sel),
    .mem_wr_req       (mem_wr_req),
    .mem_rd_req       (mem_rd_req),
    .beat_cnt         (beat_cnt),
    .data_we          (data_we),
    .data_src         (data_src)
  );

  // Observed outputs packed: {stall,rt,vi,di,idx,tsel,wr,rd,we,src,beat[1:0]}
  logic [11:0] obs;
  assign obs = {stall, replace_tag, valid_in, dirty_in, idx_sel, tag_sel,
                mem_wr_req, mem_rd_req, data_we, data_src, beat_cnt};

  function automatic logic [11:0] ev(input logic s, input logic rt, input logic vi,
                                     input logic di, input logic ix, input logic ts,
                                     input logic wr, input logic rd, input logic we,
                                     input logic src, input logic [1:0] b);
    return {s, rt, vi, di, ix, ts, wr, rd, we, src, b};
  endfunction

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (stall,rt,vi,di,idx,tsel,wr,rd,we,src,beat)",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Beat counter per cycle for a dirty store miss with mem_ready = 1,0,1,0,...
  int wb_beats [15];

  initial begin
    wb_beats = '{0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 2, 3, 3};

    rst = 1'b1; cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_misaligned = 1'b0;
    hit = 1'b1; dirty = 1'b0; hit_misaligned = 1'b0; dirty_misaligned = 1'b0;
    mem_ready = 1'b1;

    // Reset: outputs held low even with a store hit presented.
    sample();
    check("reset_outputs", obs, 12'b0);
    tick();
    sample();
    check("reset_outputs_2", obs, 12'b0);
    tick();

    // 1. Load hit, mem_ready high must be ignored in IDLE.
    rst = 1'b0; cpu_req_we = 1'b0; hit = 1'b1;
    sample();
    check("load_hit", obs, 12'b0);
    tick();
    cpu_req_valid = 1'b0;
    sample();
    check("idle_no_req", obs, 12'b0);
    tick();

    // 2. Store hit.
    cpu_req_valid = 1'b1; cpu_req_we = 1'b1; hit = 1'b1;
    sample();
    check("store_hit", obs, ev(0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 2'd0));
    tick();

    // 3. Clean load miss; request drops mid-refill but the miss completes.
    cpu_req_we = 1'b0; hit = 1'b0; dirty = 1'b0; mem_ready = 1'b1;
    sample();
    check("clean_miss_idle", obs, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
    tick();
    cpu_req_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      sample();
      check($sformatf("clean_alloc_b%0d", b), obs,
            ev(1, b == 3, b == 3, 0, 0, 0, 0, 1, 1, 1, 2'(b)));
      tick();
    end
    sample();
    check("clean_update", obs, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
    tick();
    cpu_req_valid = 1'b1; hit = 1'b1;
    sample();
    check("clean_rehit", obs, 12'b0);
    tick();

    // 4. Dirty store miss with toggling mem_ready.
    cpu_req_we = 1'b1; hit = 1'b0; dirty = 1'b1; mem_ready = 1'b1;
    sample();
    check("dirty_miss_idle", obs, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
    tick();
    for (int k = 0; k < 15; k++) begin
      mem_ready = (k % 2 == 0);
      sample();
      if (k <= 6)
        check($sformatf("dirty_wb_k%0d", k), obs,
              ev(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'(wb_beats[k])));
      else
        check($sformatf("dirty_alloc_k%0d", k), obs,
              ev(1, k == 14, k == 14, 0, 0, 0, 0, 1, mem_ready, 1, 2'(wb_beats[k])));
      tick();
    end
    mem_ready = 1'b1;
    sample();
    check("dirty_update", obs, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
    tick();
    hit = 1'b1;
    sample();
    check("dirty_store_rehit", obs, ev(0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 2'd0));
    tick();

    // 5. Reset during ALLOCATE beat 2.
    cpu_req_we = 1'b0; hit = 1'b0; dirty = 1'b0; mem_ready = 1'b1;
    sample();
    check("rst_miss_idle", obs, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
    tick();
    for (int b = 0; b < 2; b++) begin
      sample();
      check($sformatf("rst_alloc_b%0d", b), obs,
            ev(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2'(b)));
      tick();
    end
    rst = 1'b1;
    sample();
    check("rst_mid_burst", obs, 12'b0);
    tick();
    rst = 1'b0; hit = 1'b1;
    sample();
    check("rst_back_idle", obs, 12'b0);
    tick();
    cpu_req_valid = 1'b0;
    sample();
    check("rst_idle_quiet", obs, 12'b0);
    tick();

`ifdef DCACHE_MISALIGN_EN
    // 6. Misaligned: first line hits, second line misses and is dirty.
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_misaligned = 1'b1;
    hit = 1'b1; dirty = 1'b0; hit_misaligned = 1'b0; dirty_misaligned = 1'b1;
    mem_ready = 1'b1;
    sample();
    check("mis_idle", obs, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
    tick();
    for (int b = 0; b < 4; b++) begin
      sample();
      check($sformatf("mis_wb_b%0d", b), obs, ev(1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 2'(b)));
      tick();
    end
    for (int b = 0; b < 4; b++) begin
      sample();
      check($sformatf("mis_alloc_b%0d", b), obs,
            ev(1, b == 3, b == 3, 0, 1, 0, 0, 1, 1, 1, 2'(b)));
      tick();
    end
    sample();
    check("mis_update", obs, ev(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'd0));
    tick();
    hit_misaligned = 1'b1;
    sample();
    check("mis_rehit", obs, 12'b0);
    tick();
`else
    // Misalignment inputs are ignored: a first-line hit is a plain hit.
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_misaligned = 1'b1;
    hit = 1'b1; hit_misaligned = 1'b0; dirty_misaligned = 1'b1;
    sample();
    check("mis_ignored_hit", obs, 12'b0);
    tick();
    cpu_req_we = 1'b1;
    sample();
    check("mis_ignored_store", obs, ev(0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 2'd0));
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
